mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Multi-cycle controller for the memory-access stage of the non-pipelined RV32I core.
- Accepts one decoded load/store per start pulse and sequences a request/ready handshake to a variable-latency data memory.
- Generates byte enables, lane-aligned store data and sign/zero-extended load data.
- Returns a register-writeback command to the register file.
- Holds busy high so upstream stages stall until done.

Parameters:
LOAD_OP, 7'b0000011, opcode treated as load
STORE_OP, 7'b0100011, opcode treated as store
TIMEOUT, 15, max cycles waiting on mem_ready before abort (1..255)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  instruction valid from execute; sampled only in IDLE
ir  input  32  instruction word (opcode [6:0], rd [11:7], funct3 [14:12])
alu_out  input  32  effective byte address
store_data  input  32  rs2 value for stores
mem_ready  input  1  memory completes current request this cycle
mem_rdata  input  32  memory read word, valid when mem_ready=1
mem_req  output  1  request active
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  word address (alu_out with [1:0] forced to 0)
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  with done: misaligned, illegal funct3 or timeout
wb_en  output  1  register write strobe, one cycle, coincident with done
wb_rd  output  5  destination register
wb_data  output  32  formatted load result

Behaviour:
Reset (async assert): state IDLE; every output 0; timeout counter 0. A reset mid-request drops mem_req immediately.

IDLE, start=1:
- Latch ir, alu_out and store_data.
- Opcode neither LOAD_OP nor STORE_OP: go to RESP, no memory access, err=0, wb_en=0.
- Illegal funct3 (load: 011/110/111; store: anything except 000/001/010): go to RESP with err=1.
- Misaligned (half with addr[0]=1; word with addr[1:0]!=0): go to RESP with err=1.
- Otherwise go to REQ.

REQ:
- Outputs: mem_req=1; mem_we=1 for store; mem_addr, mem_be and mem_wdata held stable every cycle.
- mem_ready=1: capture mem_rdata, go to RESP with err=0.
- Timeout counter increments each REQ cycle without ready. After TIMEOUT such cycles, drop mem_req and go to RESP with err=1.
- Minimum latency start->done is 2 cycles (ready in the first REQ cycle).

RESP (one cycle, then IDLE):
- done=1.
- wb_en=1 only for a successful load with rd!=0.
- wb_rd = latched rd.
- start during RESP is ignored; a new start is accepted the following cycle in IDLE.

Byte enables and store data (a = addr[1:0]):
- Byte: be = 4'b0001 << a; wdata = {4{sd[7:0]}}.
- Half: be = 4'b0011 when a[1]=0, else 4'b1100; wdata = {2{sd[15:0]}}.
- Word: be = 4'b1111; wdata = sd.
- Loads drive be=1111; mem_wdata is don't-care but driven 0.

Load formatting:
- Shift captured word right by 8*a.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unchanged.

Other rules:
- wb_data = 0 when wb_en=0.
- mem_ready while not in REQ is ignored.
- ir/alu_out changes while busy have no effect.

Test Plan:
1. SW, addr 0x100, sd 0xDEADBEEF, ready on the 3rd REQ cycle -> mem_req high 3 cycles, we=1, be=1111, addr 0x100; done 1 cycle later, err=0, wb_en=0.
2. LB rd=5, addr 0x203, rdata 0x80FF1234 -> wb_data 0xFFFFFF80, wb_rd=5, wb_en=1. Same stimulus as LBU -> 0x00000080.
3. SH addr 0x102, sd 0x0000ABCD -> be=1100, wdata 0xABCDABCD. LH addr 0x101 -> no mem_req, done+err the next cycle.
4. LW with mem_ready held 0, TIMEOUT=15 -> mem_req for exactly 15 cycles, then done=1, err=1, wb_en=0.
5. LW rd=0 -> done=1, wb_en=0. Non-memory opcode 0110011 -> done 1 cycle after start, mem_req never asserted.
6. Assert rst during REQ -> mem_req, busy, done fall the same cycle (async). After release, a new SB completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Memory-access stage sequencer for a non-pipelined RV32I core.
//            Runs one load/store per start pulse through a req/ready handshake,
//            forms byte enables and lane-replicated store data, formats load
//            results and issues a register writeback command.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter logic [6:0] LOAD_OP  = 7'b0000011,
    parameter logic [6:0] STORE_OP = 7'b0100011,
    parameter int         TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // Last REQ cycle index before the request is abandoned.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_is_load;
    logic        r_is_store;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic [31:0] r_addr;
    logic [31:0] r_sd;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [1:0]  w_a;
    logic        w_in_load;
    logic        w_in_store;
    logic        w_f3_ok;
    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ld_data;
    logic        w_wb_ok;
    logic        w_unused_ir_hi;

    assign w_op       = ir[6:0];
    assign w_f3       = ir[14:12];
    assign w_a        = alu_out[1:0];
    assign w_in_load  = (w_op == LOAD_OP);
    assign w_in_store = (w_op == STORE_OP);
    assign w_unused_ir_hi = ^ir[31:15];

    // Decode legality of the incoming funct3 and address alignment.
    always_comb begin
        w_f3_ok   = 1'b0;
        w_aligned = 1'b1;
        if (w_in_load)
            w_f3_ok = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
        else
            w_f3_ok = (w_f3[2] == 1'b0) && (w_f3[1:0] != 2'b11);
        case (w_f3[1:0])
            2'b01:   w_aligned = ~w_a[0];
            2'b10:   w_aligned = (w_a == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    // Main sequencer: IDLE -> (REQ) -> RESP -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_f3       <= 3'd0;
            r_rd       <= 5'd0;
            r_addr     <= 32'd0;
            r_sd       <= 32'd0;
            r_cnt      <= 8'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (start) begin
                        r_is_load  <= w_in_load;
                        r_is_store <= w_in_store;
                        r_f3       <= w_f3;
                        r_rd       <= ir[11:7];
                        r_addr     <= alu_out;
                        r_sd       <= store_data;
                        if (!(w_in_load || w_in_store)) begin
                            r_err   <= 1'b0;
                            r_state <= c_ST_RESP;
                        end else if (!w_f3_ok || !w_aligned) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= c_ST_REQ;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (mem_ready) begin
                        r_rdata <= mem_rdata;
                        r_err   <= 1'b0;
                        r_state <= c_ST_RESP;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_RESP: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Byte enables, replicated store data and formatted load result.
    always_comb begin
        w_be      = 4'b1111;
        w_wdata   = 32'd0;
        w_shift   = r_rdata >> {r_addr[1:0], 3'b000};
        w_ld_data = 32'd0;
        if (r_is_store) begin
            case (r_f3[1:0])
                2'b00:   begin w_be = 4'b0001 << r_addr[1:0]; w_wdata = {4{r_sd[7:0]}};  end
                2'b01:   begin w_be = r_addr[1] ? 4'b1100 : 4'b0011; w_wdata = {2{r_sd[15:0]}}; end
                default: begin w_be = 4'b1111; w_wdata = r_sd; end
            endcase
        end
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_shift[7]}},  w_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_ld_data = w_shift;
            3'b100:  w_ld_data = {24'd0, w_shift[7:0]};
            3'b101:  w_ld_data = {16'd0, w_shift[15:0]};
            default: w_ld_data = 32'd0;
        endcase
    end

    assign w_wb_ok   = r_is_load && !r_err && (r_rd != 5'd0);

    assign mem_req   = (r_state == c_ST_REQ);
    assign mem_we    = mem_req && r_is_store;
    assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_be    = mem_req ? w_be : 4'd0;
    assign mem_wdata = mem_we ? w_wdata : 32'd0;
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_RESP);
    assign err       = done && r_err;
    assign wb_en     = done && w_wb_ok;
    assign wb_rd     = done ? r_rd : 5'd0;
    assign wb_data   = wb_en ? w_ld_data : 32'd0;

endmodule
`default_nettype wire
